ps2_key_ctrl: RTL and testbench
===============================

# ps2_key_ctrl

Sequencing controller between the `Ps2Keyboard` receive FIFO and the key-display/consumer logic. It pops scan-code bytes through the `ready`/`nextdata_n` handshake and parses multi-byte sequences: `F0` break prefix, optional `E0` extended prefix. It suppresses typematic repeats, tracks the held key and a press counter, and presents one key event at a time on a valid/ready output interface.

## Interface
Parameters:
- `CNT_W`, default 8: width of the press counter.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `kb_ready` in 1: keyboard FIFO non-empty; `kb_data` is valid while high.
- `kb_data` in 8: scan-code byte at FIFO head.
- `kb_overflow` in 1: keyboard FIFO overflow flag.
- `kb_nextdata_n` out 1: active-low pop strobe to the keyboard FIFO.
- `ev_valid` out 1: key event available.
- `ev_ready` in 1: consumer accepts the event.
- `ev_code` out 8: scan code of the event.
- `ev_break` out 1: 1 = release, 0 = press.
- `ev_ext` out 1: event was `E0`-prefixed.
- `key_held` out 1: a key is currently held.
- `held_code` out 8: code of the held key.
- `press_cnt` out CNT_W: number of accepted press events, wraps.
- `err` out 1: sticky overflow indicator.

## Operation
- FSM states:
  - IDLE: if `kb_ready`, register `kb_data` into `byte_q` and go to POP.
  - POP: drive `kb_nextdata_n`=0 for exactly this cycle, then go to SETTLE.
  - SETTLE: decode `byte_q` (see below), then go to EMIT if an event was formed, else IDLE. This one-cycle gap lets `kb_ready` reflect the pop.
  - EMIT: hold `ev_valid`=1 with stable `ev_*` until `ev_ready`=1, then go to IDLE. No FIFO pop occurs in EMIT.
- Decode of `byte_q` in SETTLE:
  - `F0`: set `brk_f`; no event.
  - `E0`: see Configuration.
  - Any other byte forms an event {`ext_f`, `brk_f`, `byte_q`}, then clears `brk_f` and `ext_f`.
- Press event:
  - If `key_held`=1 and the code and ext match the held key, the event is a typematic repeat: drop it, change no state, return to IDLE.
  - Otherwise set `key_held`=1, load `held_code`/`held_ext` and increment `press_cnt` modulo 2^CNT_W.
- Release event: always emitted. Clears `key_held` only if the code and ext match the held key; otherwise the held state is unchanged.
- A new press of a different key while one is held replaces the held key and counts.
- `00` bytes are popped and discarded with no event, and the prefix flags are kept.
- `err` is set on any cycle with `kb_overflow`=1 and is cleared only by `rst`. Parsing continues while `err` is set.

## Timing
- Reset values: state IDLE, `kb_nextdata_n`=1, `ev_valid`=0, `ev_code`=00, `ev_break`=0, `ev_ext`=0, `key_held`=0, `held_code`=00, `press_cnt`=0, `err`=0, prefix flags cleared.
- `kb_ready` high in cycle N (IDLE) gives the pop strobe in N+1, decode in N+2, and `ev_valid` from N+3.
- With `ev_ready` held high, `ev_valid` is high for one cycle. Sustained throughput is one byte per 4 cycles.
- `ev_valid` and `ev_*` change only on entry to and exit from EMIT; they are stable while stalled.
- `press_cnt` and `key_held` update at the end of the SETTLE cycle, visible together with `ev_valid`.
- `rst` asserted mid-sequence (any state, including EMIT or after `F0`) returns all state to reset values on the next edge. A partial prefix is discarded.
- `kb_ready` high during POP or SETTLE is ignored until IDLE.

## Configuration
- `PS2_KEY_CTRL_EXT_EN` defined: `E0` sets `ext_f`. The following event has `ev_ext`=1, and held-key matching includes ext.
- Not defined: `E0` is popped and discarded; `ev_ext` is tied 0 and `held_ext` is removed. Sequence `E0 75` yields code 75 with ext 0.

## Test plan
- After reset, bytes `1C`, `F0`, `1C` with `ev_ready`=1 → events (1C, break 0) then (1C, break 1). `press_cnt`=1, `key_held`=0; each `ev_valid` appears 3 cycles after `kb_ready` is sampled.
- `1C` ×5 (typematic) then `F0 1C` → exactly one press and one release event, `press_cnt`=1.
- `ev_ready`=0 for 20 cycles during EMIT → `ev_valid` and `ev_*` held stable and `kb_nextdata_n` stays 1. The event is released on the first `ev_ready`=1 cycle.
- `E0 75 F0` with `rst` pulsed after `F0`, then `F0 75` → outputs return to reset values. The macro-on build then reports (75, break 1, ext 0); `key_held` stays 0.
- Macro on: `E0 75`, `E0 F0 75` → (75, ext 1, make), (75, ext 1, break). Macro off: same stimulus gives ext 0 on both events.
- `press_cnt` at FF, new key `15` → `press_cnt`=00. `kb_overflow` pulse → `err`=1 until `rst`.

Source files
------------

// File: rtl/ps2_key_ctrl_if.sv
// ps2_key_ctrl_if: keyboard FIFO pop handshake and key-event valid/ready bundle
interface ps2_key_ctrl_if #(parameter int CNT_W = 8);
  logic             kb_ready;
  logic [7:0]       kb_data;
  logic             kb_overflow;
  logic             kb_nextdata_n;
  logic             ev_valid;
  logic             ev_ready;
  logic [7:0]       ev_code;
  logic             ev_break;
  logic             ev_ext;
  logic             key_held;
  logic [7:0]       held_code;
  logic [CNT_W-1:0] press_cnt;
  logic             err;
  modport master (
    input  kb_ready, kb_data, kb_overflow, ev_ready,
    output kb_nextdata_n, ev_valid, ev_code, ev_break, ev_ext,
           key_held, held_code, press_cnt, err
  );
  modport slave (
    output kb_ready, kb_data, kb_overflow, ev_ready,
    input  kb_nextdata_n, ev_valid, ev_code, ev_break, ev_ext,
           key_held, held_code, press_cnt, err
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: PS/2 scan-code parser with typematic suppression; PS2_KEY_CTRL_EXT_EN enables E0 tracking
module ps2_key_ctrl #(
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst,
  ps2_key_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, POP, SETTLE, EMIT} state_t;
  state_t           state;
  logic [7:0]       byte_q, code_q, held_q;
  logic             brk_f, brk_q, held_f, vld_q, nd_q, err_q, match;
  logic [CNT_W-1:0] cnt_q;
`ifdef PS2_KEY_CTRL_EXT_EN
  logic ext_f, ext_q, held_ext;
  assign match      = held_f && held_q == byte_q && held_ext == ext_f;
  assign bus.ev_ext = ext_q;
`else
  assign match      = held_f && held_q == byte_q;
  assign bus.ev_ext = 1'b0;
`endif
  assign bus.kb_nextdata_n = nd_q;
  assign bus.ev_valid      = vld_q;
  assign bus.ev_code       = code_q;
  assign bus.ev_break      = brk_q;
  assign bus.key_held      = held_f;
  assign bus.held_code     = held_q;
  assign bus.press_cnt     = cnt_q;
  assign bus.err           = err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      byte_q <= '0;
      code_q <= '0;
      held_q <= '0;
      brk_f  <= 1'b0;
      brk_q  <= 1'b0;
      held_f <= 1'b0;
      vld_q  <= 1'b0;
      nd_q   <= 1'b1;
      err_q  <= 1'b0;
      cnt_q  <= '0;
`ifdef PS2_KEY_CTRL_EXT_EN
      ext_f    <= 1'b0;
      ext_q    <= 1'b0;
      held_ext <= 1'b0;
`endif
    end else begin
      if (bus.kb_overflow) err_q <= 1'b1;
      nd_q <= 1'b1;
      case (state)
        IDLE: if (bus.kb_ready) begin
          byte_q <= bus.kb_data;
          nd_q   <= 1'b0;
          state  <= POP;
        end
        POP: state <= SETTLE;
        SETTLE: begin
          state <= IDLE;
          if (byte_q == 8'hF0) brk_f <= 1'b1;
          else if (byte_q == 8'hE0) begin
`ifdef PS2_KEY_CTRL_EXT_EN
            ext_f <= 1'b1;
`endif
          end else if (byte_q != 8'h00) begin
            brk_f <= 1'b0;
`ifdef PS2_KEY_CTRL_EXT_EN
            ext_f <= 1'b0;
`endif
            // a press matching the held key is a typematic repeat and is dropped
            if (brk_f || !match) begin
              vld_q  <= 1'b1;
              code_q <= byte_q;
              brk_q  <= brk_f;
              state  <= EMIT;
`ifdef PS2_KEY_CTRL_EXT_EN
              ext_q <= ext_f;
`endif
              if (!brk_f) begin
                held_f <= 1'b1;
                held_q <= byte_q;
                cnt_q  <= cnt_q + 1'b1;
`ifdef PS2_KEY_CTRL_EXT_EN
                held_ext <= ext_f;
`endif
              end else if (match) held_f <= 1'b0;
            end
          end
        end
        EMIT: if (bus.ev_ready) begin
          vld_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: directed checks of parsing, handshake timing, stalls, reset and wrap
module tb_ps2_key_ctrl;
  localparam int CNT_W = 8;
`ifdef PS2_KEY_CTRL_EXT_EN
  localparam logic EXT = 1'b1;
`else
  localparam logic EXT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ps2_key_ctrl_if #(.CNT_W(CNT_W)) bus ();
  ps2_key_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [7:0] q[$];
  logic [9:0] log_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic stable;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    if (bus.ev_valid && bus.ev_ready) log_q.push_back({bus.ev_ext, bus.ev_break, bus.ev_code});
    @(negedge clk);
    if (!bus.kb_nextdata_n && q.size() > 0) void'(q.pop_front());
    bus.kb_ready = q.size() > 0;
    bus.kb_data  = q.size() > 0 ? q[0] : 8'h00;
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic push(input logic [7:0] b);
    q.push_back(b);
    bus.kb_ready = 1'b1;
    bus.kb_data  = q[0];
  endtask
  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    bus.kb_ready    = 1'b0;
    bus.kb_data     = 8'h00;
    bus.kb_overflow = 1'b0;
    bus.ev_ready    = 1'b1;
    run(2);
    rst = 1'b0;
    log_q.delete();
  endtask
  initial begin
    do_reset();
    check("rst_nd_n", bus.kb_nextdata_n, 1);
    check("rst_valid", bus.ev_valid, 0);
    check("rst_code", bus.ev_code, 8'h00);
    check("rst_held", bus.key_held, 0);
    check("rst_cnt", bus.press_cnt, 0);
    check("rst_err", bus.err, 0);
    // press/release with cycle-exact latency
    push(8'h1C);
    step();
    check("pop_n1", bus.kb_nextdata_n, 0);
    check("novalid_n1", bus.ev_valid, 0);
    step();
    check("nd_n2", bus.kb_nextdata_n, 1);
    check("novalid_n2", bus.ev_valid, 0);
    step();
    check("valid_n3", bus.ev_valid, 1);
    check("code_n3", bus.ev_code, 8'h1C);
    check("cnt_n3", bus.press_cnt, 1);
    check("held_n3", bus.key_held, 1);
    push(8'hF0);
    push(8'h1C);
    run(12);
    check("t1_nev", log_q.size(), 2);
    check("t1_ev0", log_q[0], {2'b00, 8'h1C});
    check("t1_ev1", log_q[1], {2'b01, 8'h1C});
    check("t1_cnt", bus.press_cnt, 1);
    check("t1_held", bus.key_held, 0);
    // typematic repeats, 00 filler between prefix and code
    do_reset();
    repeat (5) push(8'h1C);
    push(8'hF0);
    push(8'h00);
    push(8'h1C);
    run(40);
    check("t2_nev", log_q.size(), 2);
    check("t2_ev0", log_q[0], {2'b00, 8'h1C});
    check("t2_ev1", log_q[1], {2'b01, 8'h1C});
    check("t2_cnt", bus.press_cnt, 1);
    check("t2_held", bus.key_held, 0);
    // release of a key that is not held keeps the held key
    do_reset();
    push(8'h1C);
    push(8'hF0);
    push(8'h22);
    run(20);
    check("t8_nev", log_q.size(), 2);
    check("t8_ev1", log_q[1], {2'b01, 8'h22});
    check("t8_held", bus.key_held, 1);
    check("t8_hcode", bus.held_code, 8'h1C);
    // consumer stall
    do_reset();
    bus.ev_ready = 1'b0;
    push(8'h2B);
    push(8'h34);
    run(3);
    check("t3_valid", bus.ev_valid, 1);
    stable = 1'b1;
    repeat (20) begin
      step();
      if (!(bus.ev_valid && bus.ev_code == 8'h2B && !bus.ev_break && bus.kb_nextdata_n)) stable = 1'b0;
    end
    check("t3_stable", stable, 1);
    bus.ev_ready = 1'b1;
    step();
    check("t3_release", bus.ev_valid, 0);
    check("t3_nev", log_q.size(), 1);
    check("t3_ev0", log_q[0], {2'b00, 8'h2B});
    run(6);
    // reset mid-sequence after F0
    do_reset();
    push(8'hE0);
    push(8'h75);
    push(8'hF0);
    run(14);
    rst = 1'b1;
    step();
    rst = 1'b0;
    log_q.delete();
    check("t4_valid", bus.ev_valid, 0);
    check("t4_code", bus.ev_code, 8'h00);
    check("t4_brk", bus.ev_break, 0);
    check("t4_ext", bus.ev_ext, 0);
    check("t4_held", bus.key_held, 0);
    check("t4_hcode", bus.held_code, 8'h00);
    check("t4_cnt", bus.press_cnt, 0);
    push(8'hF0);
    push(8'h75);
    run(10);
    check("t4_nev", log_q.size(), 1);
    check("t4_ev0", log_q[0], {2'b01, 8'h75});
    check("t4_held2", bus.key_held, 0);
    // extended prefix
    do_reset();
    push(8'hE0);
    push(8'h75);
    push(8'hE0);
    push(8'hF0);
    push(8'h75);
    run(24);
    check("t5_nev", log_q.size(), 2);
    check("t5_ev0", log_q[0], {EXT, 1'b0, 8'h75});
    check("t5_ev1", log_q[1], {EXT, 1'b1, 8'h75});
    check("t5_held", bus.key_held, 0);
    check("t5_cnt", bus.press_cnt, 1);
    // press counter wrap
    do_reset();
    for (int i = 0; i < 255; i++) push(i[0] ? 8'h1B : 8'h1C);
    run(255 * 4 + 8);
    check("t6_cnt_ff", bus.press_cnt, 8'hFF);
    push(8'h15);
    run(6);
    check("t6_cnt_wrap", bus.press_cnt, 8'h00);
    check("t6_hcode", bus.held_code, 8'h15);
    check("t6_held", bus.key_held, 1);
    // sticky overflow
    bus.kb_overflow = 1'b1;
    step();
    bus.kb_overflow = 1'b0;
    check("t7_err_set", bus.err, 1);
    run(5);
    check("t7_err_sticky", bus.err, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t7_err_clr", bus.err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
